digit_serial_adder: RTL and testbench
=====================================

// Module: digit_serial_adder
// PURPOSE
//  Parametrised successor to the single-bit combinational adder: a WIDTH-bit add/subtract/accumulate unit.
//  It processes DIGIT_W bits per clock, LSB digit first, with a registered carry between digits.
//  It accepts operands over a valid/ready handshake and returns a registered sum with carry and signed-overflow flags.
//  It sits behind the top-level pin wrapper and trades latency for area.
// PARAMETERS
//  WIDTH    16  operand/result width in bits; >=2.
//  DIGIT_W   4  bits added per cycle; must divide WIDTH (elaboration error otherwise).
//  NDIG     WIDTH/DIGIT_W  derived localparam; number of digit cycles.
// PORTS
//  clk        in   1      single clock, rising edge.
//  rst        in   1      synchronous, active-high reset.
//  in_valid   in   1      operand request valid.
//  in_ready   out  1      unit can accept a request (high only in IDLE).
//  in_a       in   WIDTH  operand A; ignored when in_acc=1.
//  in_b       in   WIDTH  operand B.
//  in_sub     in   1      1: A-B (two's complement); 0: A+B.
//  in_acc     in   1      1: A is replaced by the internal accumulator.
//  out_valid  out  1      result valid; held until out_ready.
//  out_ready  in   1      consumer accepts the result.
//  out_sum    out  WIDTH  result; also loaded into the accumulator.
//  out_carry  out  1      final carry out (subtract: 1 = no borrow).
//  out_ovf    out  1      signed overflow of this operation.
//  busy       out  1      high in RUN or DONE.
// BEHAVIOUR
//  - Reset (any state, mid-operation included): state=IDLE; digit counter=0; accumulator=0.
//    out_sum=0, out_carry=0, out_ovf=0, out_valid=0; in_ready=1 in the cycle after reset releases.
//    An operation in flight is discarded with no output.
//  - FSM IDLE->RUN on (in_valid & in_ready). At that edge the unit latches:
//    A_eff = in_acc ? acc : in_a;  B_eff = in_sub ? ~in_b : in_b;  carry = in_sub.
//  - RUN: each edge adds digit k of A_eff, B_eff and carry, and writes sum digit k.
//    carry <= digit carry-out; k increments 0..NDIG-1. After the edge with k=NDIG-1 the FSM goes to DONE.
//  - Latency: out_valid rises exactly NDIG cycles after the accept edge. With defaults this is 4.
//  - DONE: out_valid=1. out_sum, out_carry and out_ovf are stable and registered.
//    On (out_valid & out_ready) -> IDLE; out_valid=0 the next cycle.
//  - in_ready=0 in RUN and DONE; in_valid there is ignored (no queuing).
//    The earliest back-to-back accept is the cycle after the result handshake.
//  - Overflow: ovf = (A_eff[MSB]==B_eff[MSB]) & (raw_sum[MSB]!=A_eff[MSB]). Carry is unsigned carry out of the MSB.
//  - Accumulator: loaded with final out_sum when entering DONE, for every operation (acc or not).
//  - Arithmetic wraps modulo 2^WIDTH unless the macro below is defined.
//  - out_* hold their last values in IDLE and RUN; they only change on the transition into DONE.
// CONFIGURATION
//  Macro DIGIT_SERIAL_ADDER_SAT_EN:
//   - Defined: when ovf=1, out_sum and the accumulator take the signed saturation value.
//     That value is 0x7FF..F if A_eff[MSB]=0, else 0x800..0. out_ovf and out_carry still report the raw result.
//   - Undefined: the wrapped raw sum is used; no saturation logic is generated.
// STRUCTURE
//  - Package dsa_pkg holds:
//    - the state enum {IDLE, RUN, DONE} (2-bit encoding);
//    - the function ceil_log2 used to size the digit counter;
//    - the saturation constants SAT_POS/SAT_NEG as functions of WIDTH.
//  - Sub-module dsa_digit_add #(DIGIT_W): purely combinational DIGIT_W-bit full adder.
//    Ports a, b, cin -> s, cout, and c_into_msb for optional use. Instantiated once and shared across cycles.
//  - Top holds the FSM, digit counter, operand and result shift registers, the carry flop and the accumulator.
// TESTING (WIDTH=16, DIGIT_W=4 unless noted)
//  1. Add 0x1234 + 0x0FFF, out_ready=1 -> out_sum=0x2233, carry=0, ovf=0.
//     out_valid exactly 4 cycles after the accept edge.
//  2. Add 0x7FFF + 0x0001 -> ovf=1, carry=0. out_sum=0x8000 without the macro, 0x7FFF with it.
//     Also 0xFFFF + 0x0001 -> 0x0000, carry=1, ovf=0.
//  3. Sub 0x0005 - 0x0007 -> out_sum=0xFFFE, carry=0 (borrow), ovf=0.
//     Sub 0x8000 - 0x0001 -> ovf=1.
//  4. After reset, three accumulate ops with in_acc=1, in_b=0x0003 -> out_sum 0x0003, 0x0006, 0x0009.
//  5. Hold out_ready=0 for 5 cycles in DONE while toggling in_valid -> outputs stable, in_ready=0, no second accept.
//     Release out_ready -> in_ready=1 the next cycle.
//  6. Assert rst in the 2nd RUN cycle -> next cycle out_valid=0, in_ready=1.
//     A following acc op with in_b=0x0001 -> 0x0001.
//     Repeat scenario 1 with DIGIT_W=1, 8 and 16 -> latency 16, 2, 1.

Source files
------------

// File: rtl/dsa_pkg.sv
// Shared types and helpers for the digit-serial adder: FSM encoding,
// counter sizing and signed saturation constants.
package dsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dsa_state_t;

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Callers truncate to their own WIDTH.
  function automatic logic [63:0] sat_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/dsa_digit_add.sv
// Combinational DIGIT_W-bit full adder, shared across digit cycles.
// Zero latency; no flow control.
// Also exports the carry into the MSB so signed overflow can be derived.
module dsa_digit_add #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout,
  output logic               c_into_msb
);

  logic [DIGIT_W:0] full;

  assign full       = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
  assign s          = full[DIGIT_W-1:0];
  assign cout       = full[DIGIT_W];
  // The sum bit is a^b^cin at every position, so cin at the MSB falls out.
  assign c_into_msb = a[DIGIT_W-1] ^ b[DIGIT_W-1] ^ s[DIGIT_W-1];

endmodule

// File: rtl/digit_serial_adder.sv
// WIDTH-bit add/sub/accumulate, DIGIT_W bits per clock; DIGIT_SERIAL_ADDER_SAT_EN enables saturation.
// Latency: out_valid rises NDIG cycles after the accept edge.
// Backpressure: one op in flight; in_ready only in IDLE, result held until out_ready.
module digit_serial_adder
  import dsa_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DIGIT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? ceil_log2(NDIG) : 1;

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("digit_serial_adder: WIDTH must be >= 2");
    end
    if (DIGIT_W < 1 || (WIDTH % DIGIT_W) != 0) begin : g_bad_digit
      $error("digit_serial_adder: DIGIT_W must divide WIDTH");
    end
  endgenerate

`ifdef DIGIT_SERIAL_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_P = WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_N = WIDTH'(sat_neg(WIDTH));
`endif

  dsa_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, acc;
  logic             carry;

  logic [DIGIT_W-1:0] d_s;
  logic               d_cout, d_cmsb;
  logic [WIDTH-1:0]   sum_nxt, res;
  logic               ovf, last;

  dsa_digit_add #(.DIGIT_W(DIGIT_W)) u_digit_add (
    .a          (a_sh[DIGIT_W-1:0]),
    .b          (b_sh[DIGIT_W-1:0]),
    .cin        (carry),
    .s          (d_s),
    .cout       (d_cout),
    .c_into_msb (d_cmsb)
  );

  always_comb begin
    last    = (cnt == CNT_W'(NDIG - 1));
    sum_nxt = (sum_sh >> DIGIT_W) | (WIDTH'(d_s) << (WIDTH - DIGIT_W));
    // On the top digit, carry-in vs carry-out of the MSB differs exactly on signed overflow.
    ovf     = d_cmsb ^ d_cout;
`ifdef DIGIT_SERIAL_ADDER_SAT_EN
    res     = ovf ? (a_sh[DIGIT_W-1] ? SAT_N : SAT_P) : sum_nxt;
`else
    res     = sum_nxt;
`endif
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= in_acc ? acc : in_a;
            b_sh  <= in_sub ? ~in_b : in_b;
            carry <= in_sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT_W;
          b_sh   <= b_sh >> DIGIT_W;
          sum_sh <= sum_nxt;
          carry  <= d_cout;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            out_sum   <= res;
            acc       <= res;
            out_carry <= d_cout;
            out_ovf   <= ovf;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder (WIDTH=16): main instance DIGIT_W=4,
// side instances DIGIT_W=1/8/16 for latency scaling.
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic        in_sub = 1'b0, in_acc = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_carry, out_ovf, busy;
  logic [15:0] out_sum;

  logic        x_in_ready [3];
  logic        x_out_valid[3];
  logic [15:0] x_sum      [3];
  logic        x_carry    [3];
  logic        x_ovf      [3];
  logic        x_busy     [3];

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(16), .DIGIT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .out_ovf(out_ovf), .busy(busy)
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT_W(1)) dut_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(x_in_ready[0]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_acc(in_acc),
    .out_valid(x_out_valid[0]), .out_ready(out_ready), .out_sum(x_sum[0]),
    .out_carry(x_carry[0]), .out_ovf(x_ovf[0]), .busy(x_busy[0])
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT_W(8)) dut_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(x_in_ready[1]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_acc(in_acc),
    .out_valid(x_out_valid[1]), .out_ready(out_ready), .out_sum(x_sum[1]),
    .out_carry(x_carry[1]), .out_ovf(x_ovf[1]), .busy(x_busy[1])
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT_W(16)) dut_d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(x_in_ready[2]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_acc(in_acc),
    .out_valid(x_out_valid[2]), .out_ready(out_ready), .out_sum(x_sum[2]),
    .out_carry(x_carry[2]), .out_ovf(x_ovf[2]), .busy(x_busy[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Drives one request, returns cycles from accept edge to out_valid (60 = timeout).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic acc, output int lat);
    int n;
    in_a = a; in_b = b; in_sub = sub; in_acc = acc; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    apply_reset();
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL reset_busy got %b want 0", busy); end
    vec++; if (out_sum !== 16'h0000) begin miss++; $display("FAIL reset_out_sum got %h want 0000", out_sum); end
    vec++; if ({out_carry, out_ovf} !== 2'b00) begin miss++; $display("FAIL reset_flags got %b want 00", {out_carry, out_ovf}); end
  endtask

  task automatic test_widths();
    int lat[3];
    logic [15:0] s[3];
    int exp_lat[3];
    exp_lat[0] = 16; exp_lat[1] = 2; exp_lat[2] = 1;
    for (int j = 0; j < 3; j++) begin lat[j] = -1; s[j] = 'x; end
    in_a = 16'h1234; in_b = 16'h0FFF; in_sub = 1'b0; in_acc = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      for (int j = 0; j < 3; j++) begin
        if (x_out_valid[j] && lat[j] < 0) begin lat[j] = c; s[j] = x_sum[j]; end
      end
    end
    for (int j = 0; j < 3; j++) begin
      vec++; if (lat[j] !== exp_lat[j]) begin miss++; $display("FAIL width%0d_latency got %0d want %0d", j, lat[j], exp_lat[j]); end
      vec++; if (s[j] !== 16'h2233) begin miss++; $display("FAIL width%0d_sum got %h want 2233", j, s[j]); end
    end
  endtask

  task automatic test_add();
    int lat;
    logic [15:0] exp_sat;
    do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, lat);
    vec++; if (lat !== 4) begin miss++; $display("FAIL add_latency got %0d want 4", lat); end
    vec++; if (out_sum !== 16'h2233) begin miss++; $display("FAIL add_sum got %h want 2233", out_sum); end
    vec++; if ({out_carry, out_ovf} !== 2'b00) begin miss++; $display("FAIL add_flags got %b want 00", {out_carry, out_ovf}); end
    tick();
`ifdef DIGIT_SERIAL_ADDER_SAT_EN
    exp_sat = 16'h7FFF;
`else
    exp_sat = 16'h8000;
`endif
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    vec++; if (out_sum !== exp_sat) begin miss++; $display("FAIL add_ovf_sum got %h want %h", out_sum, exp_sat); end
    vec++; if ({out_carry, out_ovf} !== 2'b01) begin miss++; $display("FAIL add_ovf_flags got %b want 01", {out_carry, out_ovf}); end
    tick();
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    vec++; if (out_sum !== 16'h0000) begin miss++; $display("FAIL add_wrap_sum got %h want 0000", out_sum); end
    vec++; if ({out_carry, out_ovf} !== 2'b10) begin miss++; $display("FAIL add_wrap_flags got %b want 10", {out_carry, out_ovf}); end
    tick();
  endtask

  task automatic test_sub();
    int lat;
    logic [15:0] exp_sat;
    do_op(16'h0005, 16'h0007, 1'b1, 1'b0, lat);
    vec++; if (out_sum !== 16'hFFFE) begin miss++; $display("FAIL sub_borrow_sum got %h want fffe", out_sum); end
    vec++; if ({out_carry, out_ovf} !== 2'b00) begin miss++; $display("FAIL sub_borrow_flags got %b want 00", {out_carry, out_ovf}); end
    tick();
`ifdef DIGIT_SERIAL_ADDER_SAT_EN
    exp_sat = 16'h8000;
`else
    exp_sat = 16'h7FFF;
`endif
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, lat);
    vec++; if (out_sum !== exp_sat) begin miss++; $display("FAIL sub_ovf_sum got %h want %h", out_sum, exp_sat); end
    vec++; if ({out_carry, out_ovf} !== 2'b11) begin miss++; $display("FAIL sub_ovf_flags got %b want 11", {out_carry, out_ovf}); end
    tick();
  endtask

  task automatic test_accumulate();
    int lat;
    logic [15:0] exp_acc[3];
    exp_acc[0] = 16'h0003; exp_acc[1] = 16'h0006; exp_acc[2] = 16'h0009;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      do_op(16'hDEAD, 16'h0003, 1'b0, 1'b1, lat);
      vec++; if (out_sum !== exp_acc[k]) begin miss++; $display("FAIL acc_step%0d got %h want %h", k, out_sum, exp_acc[k]); end
      tick();
    end
  endtask

  task automatic test_back_pressure();
    int lat;
    out_ready = 1'b0;
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, lat);
    vec++; if (lat !== 4) begin miss++; $display("FAIL bp_latency got %0d want 4", lat); end
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      in_a = 16'hA5A5;
      tick();
      vec++; if (out_valid !== 1'b1) begin miss++; $display("FAIL bp_hold_valid cyc%0d got %b want 1", k, out_valid); end
      vec++; if (in_ready !== 1'b0) begin miss++; $display("FAIL bp_in_ready cyc%0d got %b want 0", k, in_ready); end
      vec++; if (out_sum !== 16'h0003) begin miss++; $display("FAIL bp_hold_sum cyc%0d got %h want 0003", k, out_sum); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    tick();
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL bp_no_second_accept busy got %b want 0", busy); end
    vec++; if (out_sum !== 16'h0003) begin miss++; $display("FAIL bp_idle_hold_sum got %h want 0003", out_sum); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    in_a = 16'h1111; in_b = 16'h1111; in_sub = 1'b0; in_acc = 1'b0; in_valid = 1'b1;
    lat = 0;
    while (!in_ready && lat < 50) begin tick(); lat++; end
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    vec++; if (out_sum !== 16'h0000) begin miss++; $display("FAIL midrst_out_sum got %h want 0000", out_sum); end
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin tick(); if (out_valid) seen++; end
    vec++; if (seen !== 0) begin miss++; $display("FAIL midrst_discard got %0d valid cycles want 0", seen); end
    do_op(16'hBEEF, 16'h0001, 1'b0, 1'b1, lat);
    vec++; if (out_sum !== 16'h0001) begin miss++; $display("FAIL midrst_acc got %h want 0001", out_sum); end
    tick();
  endtask

  initial begin
    test_reset();
    test_widths();
    test_add();
    test_sub();
    test_accumulate();
    test_back_pressure();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
